// File: rtl/data_mem_ls.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_ls
// Purpose  : RV64I data memory with load/store size and sign handling.
//            DEPTH x 64-bit word array, one request per cycle, response
//            pulse one cycle after acceptance. The array can be zero-filled
//            after reset by a DEPTH-cycle clear sequence.
// Ports    : clk, rst        - clock, asynchronous active-high reset
//            req_valid/ready - request handshake (ready=0 while clearing)
//            req_we          - 1 store / 0 load
//            req_addr        - byte address
//            req_funct3      - RV64I size/sign code
//            req_wdata       - right-aligned store data
//            rsp_valid       - one-cycle response pulse
//            rsp_rdata       - extended load data (0 for stores/faults)
//            rsp_fault       - illegal, misaligned or out-of-range request
//            init_done       - clear sequence finished
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_ls #(
  parameter int DEPTH          = 1024,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [63:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  output logic [63:0] rsp_rdata,
  output logic        rsp_fault,
  output logic        init_done
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_IDLE  = 1'b1;
  localparam logic [0:0] S_RESET = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic          rsp_valid_q;
  logic [63:0]   rsp_rdata_q;
  logic          rsp_fault_q;
  logic [63:0]   mem_q [DEPTH];

  // --------------------------------------------------------------------------
  // Request decode
  // --------------------------------------------------------------------------
  logic [AW-1:0] w_idx;
  logic [2:0]    w_off;
  logic [1:0]    w_sz;
  logic          w_misalign, w_oor, w_illegal, w_fault, w_accept;
  logic [7:0]    w_be_base, w_be;
  logic [63:0]   w_wdata_sh;

  assign w_idx = req_addr[AW+2:3];
  assign w_off = req_addr[2:0];
  assign w_sz  = req_funct3[1:0];

  always_comb begin
    w_misalign = 1'b0;
    w_be_base  = 8'h01;
    case (w_sz)
      2'd0: begin w_misalign = 1'b0;            w_be_base = 8'h01; end
      2'd1: begin w_misalign = req_addr[0];     w_be_base = 8'h03; end
      2'd2: begin w_misalign = |req_addr[1:0];  w_be_base = 8'hFF >> 4; end
      default: begin w_misalign = |req_addr[2:0]; w_be_base = 8'hFF; end
    endcase
  end

  // Any address bit above the array span makes the access out of range.
  assign w_oor      = |(req_addr >> (AW + 3));
  // Unsigned variants (funct3[2]=1) only exist for loads.
  assign w_illegal  = (req_funct3 == 3'b111) | (req_we & req_funct3[2]);
  assign w_fault    = w_illegal | w_misalign | w_oor;
  // Alignment is enforced by the fault check, so shifted lanes never wrap.
  assign w_be       = w_be_base << w_off;
  assign w_wdata_sh = req_wdata << {w_off, 3'b000};

  assign req_ready  = (state_q == S_IDLE);
  assign init_done  = (state_q == S_IDLE) & ~rst;
  assign w_accept   = req_valid & req_ready & ~rst;

  // --------------------------------------------------------------------------
  // Load path: read the addressed word combinationally so that a store
  // written on the previous edge is already visible.
  // --------------------------------------------------------------------------
  logic [63:0] w_word, w_load;
  logic [31:0] w_shift;

  assign w_word  = mem_q[w_idx];
  assign w_shift = 32'(w_word >> {w_off, 3'b000});

  always_comb begin
    w_load = 64'd0;
    case (req_funct3)
      3'b000:  w_load = {{56{w_shift[7]}},  w_shift[7:0]};
      3'b001:  w_load = {{48{w_shift[15]}}, w_shift[15:0]};
      3'b010:  w_load = {{32{w_shift[31]}}, w_shift[31:0]};
      3'b011:  w_load = w_word;
      3'b100:  w_load = {56'd0, w_shift[7:0]};
      3'b101:  w_load = {48'd0, w_shift[15:0]};
      3'b110:  w_load = {32'd0, w_shift[31:0]};
      default: w_load = 64'd0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Clear sequencer
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == S_CLEAR) begin
      clr_cnt_d = clr_cnt_q + AW'(1);
      if (clr_cnt_q == AW'(DEPTH - 1)) begin
        state_d = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_RESET;
      clr_cnt_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 64'd0;
      rsp_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      rsp_valid_q <= w_accept;
      rsp_fault_q <= w_accept & w_fault;
      rsp_rdata_q <= (w_accept & ~req_we & ~w_fault) ? w_load : 64'd0;
    end
  end

  // --------------------------------------------------------------------------
  // Memory array: no reset, only the clear sequence zero-fills it.
  // --------------------------------------------------------------------------
  logic w_clr_we, w_st_we;
  assign w_clr_we = (state_q == S_CLEAR) & ~rst;
  assign w_st_we  = w_accept & req_we & ~w_fault;

  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      mem_q[clr_cnt_q] <= 64'd0;
    end else if (w_st_we) begin
      for (int b = 0; b < 8; b++) begin
        if (w_be[b]) begin
          mem_q[w_idx][b*8 +: 8] <= w_wdata_sh[b*8 +: 8];
        end
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_fault = rsp_fault_q;

endmodule
`default_nettype wire
